// File: rtl/zx_vram_arb.sv
// -----------------------------------------------------------------------------
// zx_vram_arb
//   Arbitrates one synchronous single-port 8-bit screen RAM between ULA video
//   fetches and J1 CPU I/O-bus accesses, and holds the 0xFE border register.
//   The ULA always wins the RAM slot; the CPU is stalled via cpu_ready.
//
// Ports
//   clk, rst          : system clock, asynchronous active-low reset
//   cpu_addr/wdata    : CPU I/O address and write data (only wdata[7:0] used)
//   cpu_wr/cpu_rd     : level requests, held until cpu_ready
//   cpu_rdata         : read data, valid while cpu_ready=1, held until next read
//   cpu_ready         : one-cycle completion pulse
//   ula_req/vaddr     : ULA fetch strobe and screen byte address
//   vdata/vdata_valid : fetched byte, pulsed two cycles after ula_req
//   border            : border colour to the ULA
//   ram_addr/wdata/we : registered RAM control
//   ram_rdata         : RAM read data, one cycle after the ram_addr edge
// -----------------------------------------------------------------------------
module zx_vram_arb #(
    parameter logic [15:0] SCR_BASE    = 16'h4000,
    parameter int          SCR_SIZE    = 6912,
    parameter logic [15:0] BORDER_PORT = 16'h00FE,
    parameter logic [2:0]  BORDER_RST  = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        ula_req,
    input  logic [12:0] vaddr,
    output logic [7:0]  vdata,
    output logic        vdata_valid,
    output logic [2:0]  border,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RDWAIT,
        RDCAP,
        DONE
    } state_t;

    // Decode is done in 17 bits so SCR_BASE + SCR_SIZE cannot wrap.
    localparam logic [16:0] SCR_LO = {1'b0, SCR_BASE};
    localparam logic [16:0] SCR_HI = SCR_LO + 17'(SCR_SIZE);

    state_t      state;
    logic        ula_p1;    // fetch issued on the previous edge
    logic        ula_p2;    // RAM data for that fetch is on ram_rdata now
    logic        is_screen;
    logic        is_port;
    logic [15:0] offset_full;
    logic [12:0] offset;
    logic        unused_ok;

    // NOTE: continuous assigns for pure decode; no storage, so no latch risk.
    assign is_screen   = ({1'b0, cpu_addr} >= SCR_LO) && ({1'b0, cpu_addr} < SCR_HI);
    assign is_port     = (cpu_addr == BORDER_PORT);
    assign offset_full = cpu_addr - SCR_BASE;
    assign offset      = offset_full[12:0];
    assign unused_ok   = ^{cpu_wdata[15:8], offset_full[15:13]};

    // NOTE: every register here, including the datapath bytes, is reset so the
    // outputs are defined the moment rst falls; there is no memory array here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ula_p1      <= 1'b0;
            ula_p2      <= 1'b0;
            vdata       <= '0;
            vdata_valid <= 1'b0;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            border      <= BORDER_RST;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; pulses default low and
            // are raised below, so the last assignment in the block wins.
            ram_we      <= 1'b0;
            vdata_valid <= 1'b0;
            cpu_ready   <= 1'b0;

            // ULA pipeline: fixed two-edge latency, independent of the CPU.
            ula_p1 <= ula_req;
            ula_p2 <= ula_p1;
            if (ula_p2) begin
                vdata       <= ram_rdata;
                vdata_valid <= 1'b1;
            end
            if (ula_req) begin
                ram_addr <= vaddr;
            end

            unique case (state)
                IDLE: begin
                    if (cpu_wr || cpu_rd) begin
                        if (is_port) begin
                            if (cpu_wr) begin
                                border <= cpu_wdata[2:0];
                            end else begin
                                cpu_rdata <= {13'b0, border};
                            end
                            cpu_ready <= 1'b1;
                            state     <= DONE;
                        end else if (is_screen) begin
                            // The RAM slot belongs to the CPU only when the
                            // ULA is not fetching on this edge.
                            if (!ula_req) begin
                                ram_addr <= offset;
                                if (cpu_wr) begin
                                    ram_wdata <= cpu_wdata[7:0];
                                    ram_we    <= 1'b1;
                                    cpu_ready <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    state <= RDWAIT;
                                end
                            end
                        end else begin
                            if (!cpu_wr) begin
                                cpu_rdata <= '0;
                            end
                            cpu_ready <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RDWAIT: state <= RDCAP;
                RDCAP: begin
                    cpu_rdata <= {8'h00, ram_rdata};
                    cpu_ready <= 1'b1;
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zx_vram_arb.sv
// -----------------------------------------------------------------------------
// tb_zx_vram_arb
//   Scoreboard bench for zx_vram_arb. Stimulus pushes expected CPU and ULA
//   responses into queues; a monitor pops and compares on cpu_ready and
//   vdata_valid. The reference model is a plain byte array of screen RAM plus
//   the border value.
// -----------------------------------------------------------------------------
module tb_zx_vram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        ula_req = 1'b0;
    logic [12:0] vaddr = '0;
    logic [7:0]  vdata;
    logic        vdata_valid;
    logic [2:0]  border;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    always #5 clk = ~clk;

    zx_vram_arb dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .ula_req    (ula_req),
        .vaddr      (vaddr),
        .vdata      (vdata),
        .vdata_valid(vdata_valid),
        .border     (border),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    // Synchronous single-port RAM, read-first, one-cycle read latency.
    logic [7:0] mem [0:8191];
    bit         mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
            mem_init_done <= 1'b1;
            ram_rdata     <= 8'h00;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // Reference model
    bit [7:0]    ref_mem [0:6911];
    logic [2:0]  model_border = 3'd7;
    logic [15:0] last_rdata = '0;
    logic [12:0] exp_wr_off = '0;
    logic [7:0]  exp_wr_data = '0;

    typedef struct { logic [7:0] data; int cyc; } ula_exp_t;
    typedef struct { bit is_read; logic [15:0] rdata; } cpu_exp_t;
    ula_exp_t ula_q [$];
    cpu_exp_t cpu_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_count = 0;
    int vdata_count = 0;
    int ula_mode = 0;             // 0 = main drives, 1 = random, 2 = alternate
    logic [12:0] alt_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ULA fetch expectation: the byte the model holds at the issue edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst && ula_req) ula_q.push_back('{ref_mem[vaddr], cyc});
    end

    // ULA traffic generator for the random and alternating phases.
    initial forever begin
        @(negedge clk);
        if (ula_mode == 1) begin
            ula_req = 1'($urandom_range(0, 1));
            vaddr   = 13'($urandom_range(0, 6911));
        end else if (ula_mode == 2) begin
            ula_req = !ula_req;
            if (ula_req) begin
                vaddr    = alt_addr;
                alt_addr = alt_addr + 13'd1;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a response.
    initial begin
        bit prev_we = 1'b0;
        bit prev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (vdata_valid) begin
                vdata_count++;
                check("ula_q_nonempty", ula_q.size() != 0, 1);
                if (ula_q.size() != 0) begin
                    ula_exp_t e;
                    e = ula_q.pop_front();
                    check("vdata", vdata, e.data);
                    check("vdata_latency", cyc - e.cyc, 2);
                end
            end
            if (cpu_ready) begin
                check("cpu_ready_single", prev_ready, 0);
                check("cpu_q_nonempty", cpu_q.size() != 0, 1);
                if (cpu_q.size() != 0) begin
                    cpu_exp_t c;
                    logic [15:0] exp;
                    c   = cpu_q.pop_front();
                    exp = c.is_read ? c.rdata : last_rdata;
                    check("cpu_rdata", cpu_rdata, exp);
                    last_rdata = exp;
                end
            end
            if (ram_we) begin
                we_count++;
                check("ram_we_single", prev_we, 0);
                check("ram_we_addr", ram_addr, exp_wr_off);
                check("ram_we_data", ram_wdata, exp_wr_data);
                check("ram_we_vs_ula", ula_req, 0);
            end
            prev_we    = ram_we;
            prev_ready = cpu_ready;
        end
    end

    // One CPU transaction: push the expectation, hold the request until
    // cpu_ready, check latency against the slot-availability rule.
    task automatic cpu_txn(input bit wr, input bit rd, input logic [15:0] addr,
                           input logic [15:0] wd);
        bit       scr, prt;
        int       off, n, issue_n;
        cpu_exp_t e;
        scr = (addr >= 16'h4000) && (addr < 16'h5B00);
        prt = (addr == 16'h00FE);
        off = scr ? int'(addr) - 16'h4000 : 0;
        e.is_read = !wr;
        e.rdata   = prt ? {13'b0, model_border} : (scr ? {8'h00, ref_mem[off]} : 16'h0000);
        if (wr && scr) begin
            exp_wr_off  = 13'(off);
            exp_wr_data = wd[7:0];
        end
        @(negedge clk);
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_wr    = wr;
        cpu_rd    = rd;
        cpu_q.push_back(e);
        n = 0;
        issue_n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (issue_n == 0 && !(scr && ula_req)) issue_n = n;
        end while (!cpu_ready && n < 200);
        if (!cpu_ready) begin
            check("cpu_ready_timeout", cpu_ready, 1);
        end else begin
            check("cpu_latency", n, issue_n + ((scr && !wr) ? 2 : 0));
            if (wr && scr) ref_mem[off] = wd[7:0];
            if (wr && prt) begin
                model_border = wd[2:0];
                check("border", border, model_border);
            end
        end
        @(negedge clk);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    task automatic ula_stop();
        @(posedge clk);
        ula_mode = 0;
        @(negedge clk);
        ula_req = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int base_we, base_vd;
        logic [15:0] boundary [4];
        boundary[0] = 16'h3FFF;
        boundary[1] = 16'h5B00;
        boundary[2] = 16'h0000;
        boundary[3] = 16'hFFFF;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_border", border, 3'd7);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_vdata_valid", vdata_valid, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ram_addr", ram_addr, 0);

        // Border port
        cpu_txn(1, 0, 16'h00FE, 16'h0002);
        cpu_txn(0, 1, 16'h00FE, 16'h0000);
        cpu_txn(1, 0, 16'h00FE, 16'h0002);   // unchanged value

        // Screen write / read at offset 0
        base_we = we_count;
        cpu_txn(1, 0, 16'h4000, 16'h00A5);
        cpu_txn(0, 1, 16'h4000, 16'h0000);
        check("screen_we_pulses", we_count - base_we, 1);

        // Four back-to-back ULA fetches of preloaded bytes
        for (int i = 0; i < 4; i++) cpu_txn(1, 0, 16'h5800 + 16'(i), 16'h0011 + 16'(i));
        base_vd = vdata_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ula_req = 1'b1;
            vaddr   = 13'h1800 + 13'(i);
        end
        @(negedge clk);
        ula_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ula_burst_pulses", vdata_count - base_vd, 4);

        // CPU read of the last screen byte against alternating ULA traffic
        cpu_txn(1, 0, 16'h5AFF, 16'h00C3);
        alt_addr = 13'h1800;
        ula_mode = 2;
        cpu_txn(0, 1, 16'h5AFF, 16'h0000);
        cpu_txn(1, 0, 16'h5AFE, 16'h005A);
        cpu_txn(0, 1, 16'h5AFE, 16'h0000);
        ula_stop();

        // Just outside the screen window: no RAM access, data 0
        base_we = we_count;
        cpu_txn(0, 1, 16'h5B00, 16'h0000);
        cpu_txn(0, 1, 16'h3FFF, 16'h0000);
        cpu_txn(1, 0, 16'h5B00, 16'h00EE);
        check("outside_no_we", we_count - base_we, 0);

        // Write and read together is a write
        cpu_txn(1, 1, 16'h4001, 16'h0077);
        cpu_txn(0, 1, 16'h4001, 16'h0000);

        // Reset while a read sits in RDWAIT
        @(negedge clk);
        cpu_addr = 16'h4000;
        cpu_rd   = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_cpu_ready", cpu_ready, 0);
        check("mid_rst_ram_we", ram_we, 0);
        check("mid_rst_border", border, 3'd7);
        check("mid_rst_cpu_rdata", cpu_rdata, 0);
        check("mid_rst_vdata_valid", vdata_valid, 0);
        cpu_rd       = 1'b0;
        model_border = 3'd7;
        last_rdata   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        cpu_txn(0, 1, 16'h4000, 16'h0000);
        cpu_txn(0, 1, 16'h00FE, 16'h0000);

        // Randomised traffic with random ULA fetches
        ula_mode = 1;
        repeat (300) begin
            logic [15:0] a;
            int r, k;
            r = $urandom_range(0, 9);
            if (r <= 5)      a = 16'h4000 + 16'($urandom_range(0, 6911));
            else if (r <= 7) a = 16'h00FE;
            else if (r == 8) a = boundary[$urandom_range(0, 3)];
            else             a = 16'($urandom);
            k = $urandom_range(0, 2);
            cpu_txn(k != 1, k != 0, a, 16'($urandom));
        end
        ula_stop();

        check("ula_q_drained", ula_q.size(), 0);
        check("cpu_q_drained", cpu_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
